// File: rtl/parallel_to_serial_tx_if.sv
// Word-side and line-side signals of the 0x5A-framed serial transmitter.
// The master drives the word handshake; the slave is the transmitter itself.
interface parallel_to_serial_tx_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] P_IN;
   logic              P_LOAD;
   logic              P_READY;
   logic              S_OUT;
   logic              S_ACTIVE;
   logic              DONE;

   modport master (
      output P_IN, P_LOAD,
      input  P_READY, S_OUT, S_ACTIVE, DONE
   );

   modport slave (
      input  P_IN, P_LOAD,
      output P_READY, S_OUT, S_ACTIVE, DONE
   );
endinterface

// File: rtl/parallel_to_serial_tx.sv
// Serializes a sync byte then a DATA_W-bit word, MSB first, onto a registered line.
// Define PARALLEL_TO_SERIAL_TX_PARITY_EN to append one even-parity bit per frame.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | line at 0, ready for a word
// ST_SYNC   | sync pattern bit cnt_q on S_OUT
// ST_DATA   | payload bit cnt_q on S_OUT; cnt_q==0 is the last payload bit
// ST_PARITY | even-parity bit on S_OUT (optional build only)
module parallel_to_serial_tx #(
   parameter int                DATA_W    = 32,
   parameter int                SYNC_W    = 8,
   parameter logic [SYNC_W-1:0] SYNC_WORD = 8'h5A
) (
   input  logic                     CLK,
   input  logic                     RESET,
   parallel_to_serial_tx_if.slave   bus
);

   localparam int CNT_W = $clog2((DATA_W > SYNC_W) ? DATA_W : SYNC_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2
`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
      , ST_PARITY = 2'd3
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SYNC_W-1:0]   sync_sr_q, sync_sr_d;
   logic [DATA_W-1:0]   data_sr_q, data_sr_d;
   logic                s_out_q, s_out_d;
`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif

   logic last_bit;
   logic p_ready;
   logic accept;

`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
   assign last_bit = (state_q == ST_PARITY);
`else
   assign last_bit = (state_q == ST_DATA) && (cnt_q == '0);
`endif

   // Ready in the last-bit cycle lets the next frame follow with no idle gap.
   assign p_ready = (state_q == ST_IDLE) || last_bit;
   assign accept  = bus.P_LOAD && p_ready;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sync_sr_q <= '0;
         data_sr_q <= '0;
         s_out_q   <= 1'b0;
`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sync_sr_q <= sync_sr_d;
         data_sr_q <= data_sr_d;
         s_out_q   <= s_out_d;
`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sync_sr_d = sync_sr_q;
      data_sr_d = data_sr_q;
      s_out_d   = s_out_q;
`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
      parity_d  = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            s_out_d = 1'b0;
         end
         ST_SYNC: begin
            if (cnt_q == '0) begin
               state_d   = ST_DATA;
               cnt_d     = CNT_W'(DATA_W - 1);
               s_out_d   = data_sr_q[DATA_W-1];
               data_sr_d = {data_sr_q[DATA_W-2:0], 1'b0};
            end else begin
               cnt_d     = cnt_q - 1'b1;
               s_out_d   = sync_sr_q[SYNC_W-1];
               sync_sr_d = {sync_sr_q[SYNC_W-2:0], 1'b0};
            end
         end
         ST_DATA: begin
            if (cnt_q == '0) begin
`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
               state_d = ST_PARITY;
               s_out_d = parity_q;
`else
               state_d = ST_IDLE;
               s_out_d = 1'b0;
`endif
            end else begin
               cnt_d     = cnt_q - 1'b1;
               s_out_d   = data_sr_q[DATA_W-1];
               data_sr_d = {data_sr_q[DATA_W-2:0], 1'b0};
            end
         end
`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
         ST_PARITY: begin
            state_d = ST_IDLE;
            s_out_d = 1'b0;
         end
`endif
         default: begin
            state_d = ST_IDLE;
            s_out_d = 1'b0;
         end
      endcase

      // The sync MSB goes straight onto the line at accept, so the shifter holds the rest.
      if (accept) begin
         state_d   = ST_SYNC;
         cnt_d     = CNT_W'(SYNC_W - 1);
         s_out_d   = SYNC_WORD[SYNC_W-1];
         sync_sr_d = {SYNC_WORD[SYNC_W-2:0], 1'b0};
         data_sr_d = bus.P_IN;
`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
         parity_d  = ^bus.P_IN;
`endif
      end
   end

   assign bus.P_READY  = p_ready;
   assign bus.S_OUT    = s_out_q;
   assign bus.S_ACTIVE = (state_q != ST_IDLE);
   assign bus.DONE     = last_bit;

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Directed bench for parallel_to_serial_tx: vector table plus hand-written corner sequences,
// with a simple serial receiver model on S_OUT for the loopback check.
module tb_parallel_to_serial_tx;

`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
   localparam int FL = 41;
`else
   localparam int FL = 40;
`endif

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   parallel_to_serial_tx_if #(.DATA_W(32)) bus ();

   parallel_to_serial_tx #(
      .DATA_W(32),
      .SYNC_W(8),
      .SYNC_WORD(8'h5A)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .bus(bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic sout_buf [0:127];
   logic act_buf  [0:127];
   logic done_buf [0:127];
   logic rdy_buf  [0:127];
   logic exp_sout [0:127];
   logic exp_act  [0:127];
   logic exp_done [0:127];
   logic exp_rdy  [0:127];

   // Receiver model: gathers FL bits per active stretch and checks the sync byte.
   logic [40:0] rx_sr;
   logic [40:0] rx_fr;
   int          rx_cnt;
   int          rx_frames;
   logic [31:0] rx_word;
   logic        rx_valid;
   assign rx_fr = {rx_sr[39:0], bus.S_OUT};

   always @(posedge CLK) begin
      if (RESET) begin
         rx_cnt <= 0;
         rx_sr  <= '0;
      end else if (bus.S_ACTIVE) begin
         rx_sr <= rx_fr;
         if (rx_cnt == FL - 1) begin
            rx_cnt    <= 0;
            rx_frames <= rx_frames + 1;
`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
            rx_word   <= rx_fr[32:1];
            rx_valid  <= (rx_fr[40:33] == 8'h5A) && (rx_fr[0] == ^rx_fr[32:1]);
`else
            rx_word   <= rx_fr[31:0];
            rx_valid  <= (rx_fr[39:32] == 8'h5A);
`endif
         end else begin
            rx_cnt <= rx_cnt + 1;
         end
      end else begin
         rx_cnt <= 0;
      end
   end

   typedef struct {
      logic [31:0] p_in;
      logic        exp_par;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_exp();
      for (int i = 0; i < 128; i++) begin
         exp_sout[i] = 1'b0;
         exp_act[i]  = 1'b0;
         exp_done[i] = 1'b0;
         exp_rdy[i]  = 1'b1;
      end
   endtask

   task automatic add_frame(input int off, input logic [31:0] d, input logic par);
      logic [7:0] sync;
      sync = 8'h5A;
      for (int j = 0; j < 8; j++)  exp_sout[off + 1 + j] = sync[7 - j];
      for (int j = 0; j < 32; j++) exp_sout[off + 9 + j] = d[31 - j];
`ifdef PARALLEL_TO_SERIAL_TX_PARITY_EN
      exp_sout[off + 41] = par;
`else
      if (par === 1'bx) exp_sout[off + 1] = 1'bx;
`endif
      for (int j = 1; j <= FL; j++) begin
         exp_act[off + j]  = 1'b1;
         exp_rdy[off + j]  = (j == FL);
         exp_done[off + j] = (j == FL);
      end
   endtask

   task automatic start(input logic [31:0] d);
      @(negedge CLK);
      bus.P_IN   = d;
      bus.P_LOAD = 1'b1;
      chk("ready_before_accept", {31'd0, bus.P_READY}, 32'd1);
   endtask

   // Samples base+1..base+n; optional one-cycle load pulse and a load drop (which also scrambles P_IN).
   task automatic capture(input int base, input int n, input int pulse_at,
                          input logic [31:0] pulse_dat, input int drop_at);
      for (int i = 1; i <= n; i++) begin
         @(negedge CLK);
         sout_buf[base + i] = bus.S_OUT;
         act_buf[base + i]  = bus.S_ACTIVE;
         done_buf[base + i] = bus.DONE;
         rdy_buf[base + i]  = bus.P_READY;
         if (base + i == drop_at) begin
            bus.P_LOAD = 1'b0;
            bus.P_IN   = ~bus.P_IN;
         end
         if (base + i == pulse_at) begin
            bus.P_LOAD = 1'b1;
            bus.P_IN   = pulse_dat;
         end else if (base + i == pulse_at + 1) begin
            bus.P_LOAD = 1'b0;
         end
      end
   endtask

   task automatic check_stream(input string tag, input int n);
      for (int i = 1; i <= n; i++) begin
         chk($sformatf("%s.s_out[%0d]", tag, i),    {31'd0, sout_buf[i]}, {31'd0, exp_sout[i]});
         chk($sformatf("%s.s_active[%0d]", tag, i), {31'd0, act_buf[i]},  {31'd0, exp_act[i]});
         chk($sformatf("%s.done[%0d]", tag, i),     {31'd0, done_buf[i]}, {31'd0, exp_done[i]});
         chk($sformatf("%s.p_ready[%0d]", tag, i),  {31'd0, rdy_buf[i]},  {31'd0, exp_rdy[i]});
      end
   endtask

   vec_t vecs [6];
   int   frames_before;

   initial begin
      vecs[0] = '{32'hDEADBEEF, 1'b0};
      vecs[1] = '{32'h00000007, 1'b1};
      vecs[2] = '{32'h00000003, 1'b0};
      vecs[3] = '{32'hCAFEF00D, 1'b0};
      vecs[4] = '{32'h80000000, 1'b1};
      vecs[5] = '{32'hFFFFFFFF, 1'b0};

      rx_frames  = 0;
      rx_word    = '0;
      rx_valid   = 1'b0;
      RESET      = 1'b1;
      bus.P_LOAD = 1'b0;
      bus.P_IN   = '0;
      repeat (3) @(negedge CLK);
      chk("reset.s_out",    {31'd0, bus.S_OUT},    32'd0);
      chk("reset.s_active", {31'd0, bus.S_ACTIVE}, 32'd0);
      chk("reset.done",     {31'd0, bus.DONE},     32'd0);
      chk("reset.p_ready",  {31'd0, bus.P_READY},  32'd1);
      RESET = 1'b0;

      // Single frames from the table.
      for (int v = 0; v < 6; v++) begin
         clear_exp();
         start(vecs[v].p_in);
         capture(0, FL + 1, -1, 32'd0, 1);
         add_frame(0, vecs[v].p_in, vecs[v].exp_par);
         check_stream($sformatf("vec%0d", v), FL + 1);
      end

      // Back-to-back with P_LOAD held high.
      clear_exp();
      start(32'h00000001);
      capture(0, 1, -1, 32'd0, -1);
      bus.P_IN = 32'hFFFFFFFF;
      capture(1, 2 * FL, -1, 32'd0, FL + 1);
      add_frame(0, 32'h00000001, 1'b1);
      add_frame(FL, 32'hFFFFFFFF, 1'b0);
      check_stream("b2b", 2 * FL + 1);

      // Load pulse while busy is ignored.
      clear_exp();
      start(32'hA5A5A5A5);
      capture(0, FL + 1, 5, 32'h12345678, 1);
      add_frame(0, 32'hA5A5A5A5, 1'b0);
      check_stream("busy_load", FL + 1);

      // Reset mid-frame.
      clear_exp();
      start(32'h87654321);
      capture(0, 20, -1, 32'd0, 1);
      add_frame(0, 32'h87654321, 1'b1);
      check_stream("pre_abort", 20);
      RESET = 1'b1;
      @(negedge CLK);
      chk("abort.s_out",    {31'd0, bus.S_OUT},    32'd0);
      chk("abort.s_active", {31'd0, bus.S_ACTIVE}, 32'd0);
      chk("abort.p_ready",  {31'd0, bus.P_READY},  32'd1);
      chk("abort.done",     {31'd0, bus.DONE},     32'd0);
      RESET = 1'b0;
      clear_exp();
      capture(0, FL, -1, 32'd0, -1);
      check_stream("post_abort_idle", FL);

      // RESET and P_LOAD together: no accept.
      @(negedge CLK);
      RESET      = 1'b1;
      bus.P_LOAD = 1'b1;
      bus.P_IN   = 32'hFFFF0000;
      @(negedge CLK);
      chk("rst_load.s_active", {31'd0, bus.S_ACTIVE}, 32'd0);
      RESET      = 1'b0;
      bus.P_LOAD = 1'b0;
      @(negedge CLK);
      chk("rst_load.s_active_after", {31'd0, bus.S_ACTIVE}, 32'd0);
      chk("rst_load.s_out_after",    {31'd0, bus.S_OUT},    32'd0);

      clear_exp();
      start(32'h0000FFFF);
      capture(0, FL + 1, -1, 32'd0, 1);
      add_frame(0, 32'h0000FFFF, 1'b0);
      check_stream("after_abort", FL + 1);

      // Loopback into the receiver model.
      frames_before = rx_frames;
      start(32'hCAFEF00D);
      capture(0, FL + 1, -1, 32'd0, 1);
      chk("loopback.word",   rx_word, 32'hCAFEF00D);
      chk("loopback.valid",  {31'd0, rx_valid}, 32'd1);
      chk("loopback.frames", rx_frames - frames_before, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/parallel_to_serial_tx.md
Name: parallel_to_serial_tx

Overview:
- Transmit side of the 0x5A-framed serial link; its counterpart is the serial-to-parallel receiver.
- Accepts a 32-bit parallel word through a valid/ready handshake.
- Serializes one frame onto S_OUT: the 8-bit sync pattern MSB first, then the data word MSB first.
- Sits at the sender end of the link and drives the receiver's S_IN directly, on the same CLK.

Parameters:
- DATA_W, 32, width of the payload word; the bit counter must be sized for DATA_W.
- SYNC_W, 8, width of the sync pattern.
- SYNC_WORD, 8'h5A, sync pattern transmitted before each payload.

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- P_IN  input  DATA_W  parallel word to send; sampled only on accept.
- P_LOAD  input  1  word-valid request.
- P_READY  output  1  block can accept a word this cycle.
- S_OUT  output  1  serial line, registered.
- S_ACTIVE  output  1  high while a frame bit is on S_OUT.
- DONE  output  1  one-cycle pulse coincident with the last frame bit.

Behaviour:
- Reset: RESET=1 at an edge forces the following, regardless of any frame in progress:
  - state IDLE; S_OUT=0, S_ACTIVE=0, DONE=0
  - shift register and counter cleared
  - P_READY=1 from the first cycle after reset
- Abort: reset mid-frame discards the frame; no partial DONE.
- Idle line level: S_OUT=0.
- State machine: IDLE -> SYNC -> DATA -> (PARITY, optional) -> IDLE or SYNC.
- Accept: occurs at an edge where P_LOAD=1 and P_READY=1.
  - P_IN is latched into the shift register; SYNC_WORD is latched into the sync shifter.
  - Changes to P_IN after accept have no effect.
- P_READY is combinational from state:
  - 1 in IDLE;
  - 1 during the final frame-bit cycle (last DATA bit, or the PARITY bit when enabled);
  - 0 otherwise.
- P_LOAD while P_READY=0 is ignored, not queued.
- Timing, with the accept edge at cycle k:
  - S_OUT = SYNC_WORD[7..0] in cycles k+1..k+8;
  - S_OUT = P_IN[31..0] in cycles k+9..k+40;
  - S_ACTIVE=1 for exactly those 40 cycles.
- DONE=1 only in cycle k+40, while S_OUT carries P_IN[0].
- Back-to-back: an accept in the last-bit cycle moves directly to SYNC.
  - The next frame's sync bit 7 appears in the very next cycle; no idle gap.
  - S_ACTIVE stays 1 across the two frames.
- Otherwise the block returns to IDLE: S_OUT=0, S_ACTIVE=0.
- Counter: counts down from DATA_W-1 to 0 in DATA, and SYNC_W-1 to 0 in SYNC.
  - No wrap beyond 0; the state changes on 0.
- Simultaneous RESET and P_LOAD: RESET wins; no accept.

Optional Feature:
- Macro: PARALLEL_TO_SERIAL_TX_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of all 32 data bits) is sent in cycle k+41 after P_IN[0].
  - Frame length is 41 cycles.
  - DONE and the back-to-back P_READY window move to the parity cycle; S_ACTIVE covers 41 cycles.
- Undefined: no PARITY state, 40-cycle frame, exactly as described in Behaviour.

Test Plan:
- Single frame: reset, then accept P_IN=32'hDEADBEEF at cycle k.
  - Expect S_OUT 0,1,0,1,1,0,1,0 in k+1..k+8, then the bits of DEADBEEF MSB first in k+9..k+40.
  - Expect DONE only at k+40 and S_OUT=0 at k+41.
- Back-to-back: hold P_LOAD=1 with 32'h00000001 then 32'hFFFFFFFF.
  - Expect the second sync 0x5A to start at k+41 with no gap; S_ACTIVE=1 for 80 continuous cycles; two DONE pulses at k+40 and k+80.
- Load while busy: pulse P_LOAD with 32'h12345678 at k+5 during a 32'hA5A5A5A5 frame.
  - Expect the serial data to be A5A5A5A5 and exactly one DONE.
- Reset mid-frame: assert RESET at k+20.
  - Expect S_OUT=0, S_ACTIVE=0 and P_READY=1 from the next cycle; no DONE.
  - A new accept of 32'h0000FFFF transmits a complete, correct frame.
- Loopback: drive the serial-to-parallel receiver's S_IN from S_OUT.
  - Send 32'hCAFEF00D; expect the receiver's P_OUT=32'hCAFEF00D with its P_VALID asserted.
- Parity (with macro defined): send 32'h00000007.
  - Expect parity bit 1 at k+41, DONE at k+41, and S_ACTIVE for 41 cycles.
  - Sending 32'h00000003 gives parity bit 0.
